// File: rtl/guitar_pkg.sv
// Shared game-level definitions for the falling-note game.
package guitar_pkg;

  // Game-state encoding, also decoded by the VGA display logic.
  typedef enum logic [1:0] {
    GS_TITLE = 2'b00,
    GS_PLAY  = 2'b01,
    GS_OVER  = 2'b10
  } game_state_t;

  localparam int NUM_LANES_DEF = 4;
  localparam int SCORE_W       = 16;
  localparam int MISS_W        = 4;
  localparam int SPEED_W       = 50;

endpackage

// File: rtl/note_scheduler_if.sv
// Signals between the switches/lane array and the note scheduler.
interface note_scheduler_if #(
  parameter int NUM_LANES = guitar_pkg::NUM_LANES_DEF
);
  logic                            StartSwitch;
  logic [NUM_LANES-1:0]            point_in;
  logic [NUM_LANES-1:0]            gone_in;
  logic [NUM_LANES-1:0]            spawn;
  logic [NUM_LANES-1:0]            lane_busy;
  logic [guitar_pkg::SPEED_W-1:0]  speedshift;
  logic [guitar_pkg::SCORE_W-1:0]  score;
  logic [guitar_pkg::MISS_W-1:0]   miss_count;
  logic [1:0]                      gamestate;

  // Game glue and lanes drive requests/events and consume the schedule.
  modport master (
    output StartSwitch, point_in, gone_in,
    input  spawn, lane_busy, speedshift, score, miss_count, gamestate
  );

  // The scheduler itself.
  modport slave (
    input  StartSwitch, point_in, gone_in,
    output spawn, lane_busy, speedshift, score, miss_count, gamestate
  );
endinterface

// File: rtl/note_chart_rom.sv
// Fixed note chart: 16 base patterns, rotated by one lane per 16-entry block
// so that consecutive passes through the base table differ. Read latency is
// one cycle; the address is held for a whole beat so the data is settled
// well before it is used.
module note_chart_rom #(
  parameter int CHART_LEN = 64,
  parameter int NUM_LANES = 4
) (
  input  logic                         clk,
  input  logic [$clog2(CHART_LEN)-1:0] addr,
  output logic [NUM_LANES-1:0]         data
);
  localparam int IDX_W = $clog2(CHART_LEN);

  function automatic logic [3:0] base_pattern(input logic [3:0] i);
    case (i)
      4'd0:    return 4'b0101;
      4'd1:    return 4'b0001;
      4'd2:    return 4'b0010;
      4'd3:    return 4'b1000;
      4'd4:    return 4'b0100;
      4'd5:    return 4'b0011;
      4'd6:    return 4'b1100;
      4'd7:    return 4'b0000;
      4'd8:    return 4'b1001;
      4'd9:    return 4'b0110;
      4'd10:   return 4'b1111;
      4'd11:   return 4'b0001;
      4'd12:   return 4'b1010;
      4'd13:   return 4'b0100;
      4'd14:   return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] chart_word(input logic [IDX_W-1:0] a);
    logic [31:0]          ai;
    logic [3:0]           b;
    logic [NUM_LANES-1:0] w;
    logic [NUM_LANES-1:0] r;
    int                   sh;
    ai = {{(32-IDX_W){1'b0}}, a};
    b  = base_pattern(ai[3:0]);
    sh = int'((ai >> 4) % NUM_LANES);
    w  = '0;
    r  = '0;
    for (int i = 0; i < NUM_LANES; i++) w[i] = b[i % 4];
    for (int i = 0; i < NUM_LANES; i++) r[(i + sh) % NUM_LANES] = w[i];
    return r;
  endfunction

  // Registered table lookup.
  always_ff @(posedge clk) begin
    data <= chart_word(addr);
  end
endmodule

// File: rtl/note_scheduler.sv
// Game-level controller: TITLE/PLAY/OVER machine, beat-timed chart playback
// with per-lane spawn pulses, lane ownership tracking, score/miss counting
// and the fall-speed ramp.
//
// state | meaning
// TITLE | idle on title screen, waiting for StartSwitch
// PLAY  | chart running, hits and misses counted
// OVER  | miss limit reached, final values held until StartSwitch drops
module note_scheduler
  import guitar_pkg::*;
#(
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int BEAT_TICKS = 12500000,
  parameter int CHART_LEN  = 64,
  parameter int MAX_MISSES = 8,
  parameter int SPEED_STEP = 2000,
  parameter int SPEED_MAX  = 150000
) (
  input  logic            clk,
  input  logic            reset,
  note_scheduler_if.slave bus
);
  localparam int IDX_W  = $clog2(CHART_LEN);
  localparam int BEAT_W = $clog2(BEAT_TICKS);
  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEAT_TICKS - 1);
  localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);
  localparam logic [SPEED_W-1:0] SPEED_INC  = SPEED_W'(SPEED_STEP);
  localparam logic [SPEED_W-1:0] SPEED_CAP  = SPEED_W'(SPEED_MAX);

  game_state_t state_q, state_d;

  logic [BEAT_W-1:0]    beat_cnt;
  logic [IDX_W-1:0]     chart_idx;
  logic [NUM_LANES-1:0] chart_mask;
  logic [NUM_LANES-1:0] spawn_q, busy_q, gone_q, gone_rise;
  logic [NUM_LANES-1:0] point_now, gone_now;
  logic [SCORE_W-1:0]   score_q, score_nxt;
  logic [SCORE_W-5:0]   score_hi_prev;
  logic [MISS_W-1:0]    miss_q, miss_nxt;
  logic [SPEED_W-1:0]   speed_q, speed_nxt;
  logic [SCORE_W:0]     score_sum;
  logic [MISS_W:0]      miss_sum;
  logic [SPEED_W:0]     speed_sum;
  logic [CNT_W-1:0]     hits, misses;
  logic                 in_play, enter_play, stay_play, beat_tick, score_up;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign point_now = bus.point_in;
  assign gone_now  = bus.gone_in;
  assign gone_rise = gone_now & ~gone_q;

  note_chart_rom #(
    .CHART_LEN (CHART_LEN),
    .NUM_LANES (NUM_LANES)
  ) u_chart_rom (
    .clk  (clk),
    .addr (chart_idx),
    .data (chart_mask)
  );

  // Game state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= GS_TITLE;
    else       state_q <= state_d;
  end

  // Next-state decode; a player quitting takes priority over the miss limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GS_TITLE: if (bus.StartSwitch) state_d = GS_PLAY;
      GS_PLAY: begin
        if (!bus.StartSwitch)          state_d = GS_TITLE;
        else if (miss_q >= MISS_LIMIT) state_d = GS_OVER;
      end
      GS_OVER:  if (!bus.StartSwitch) state_d = GS_TITLE;
      default:  state_d = GS_TITLE;
    endcase
    in_play    = (state_q == GS_PLAY);
    enter_play = !in_play && (state_d == GS_PLAY);
    stay_play  = in_play && (state_d == GS_PLAY);
    beat_tick  = in_play && (beat_cnt == BEAT_LAST);
  end

  // Saturating score, miss and speed arithmetic.
  always_comb begin
    hits      = popcnt(point_now);
    misses    = popcnt(gone_rise);
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(hits);
    score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    miss_sum  = {1'b0, miss_q} + (MISS_W+1)'(misses);
    miss_nxt  = (miss_sum >= {1'b0, MISS_LIMIT}) ? MISS_LIMIT : miss_sum[MISS_W-1:0];
    speed_sum = {1'b0, speed_q} + {1'b0, SPEED_INC};
    speed_nxt = (speed_sum > {1'b0, SPEED_CAP}) ? SPEED_CAP : speed_sum[SPEED_W-1:0];
    score_up  = score_q[SCORE_W-1:4] > score_hi_prev;
  end

  // Beat counter and chart position; both frozen outside PLAY.
  always_ff @(posedge clk) begin
    if (reset || enter_play) begin
      beat_cnt  <= '0;
      chart_idx <= '0;
    end else if (in_play) begin
      if (beat_cnt == BEAT_LAST) begin
        beat_cnt  <= '0;
        chart_idx <= chart_idx + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Spawn pulse on a beat tick, skipping busy lanes and any tick on which
  // the game is leaving PLAY.
  always_ff @(posedge clk) begin
    if (reset)                       spawn_q <= '0;
    else if (beat_tick && stay_play) spawn_q <= chart_mask & ~busy_q;
    else                             spawn_q <= '0;
  end

  // Lane ownership (spawn beats a same-cycle clear) and gone_in edge history.
  always_ff @(posedge clk) begin
    if (reset || enter_play) begin
      busy_q <= '0;
      gone_q <= '0;
    end else begin
      busy_q <= (busy_q & ~(point_now | gone_rise)) | spawn_q;
      gone_q <= gone_now;
    end
  end

  // Score and miss counters, live only during PLAY.
  always_ff @(posedge clk) begin
    if (reset || enter_play) begin
      score_q <= '0;
      miss_q  <= '0;
    end else if (in_play) begin
      score_q <= score_nxt;
      miss_q  <= miss_nxt;
    end
  end

  // Speed ramp: one step each time the score passes a multiple of 16.
  always_ff @(posedge clk) begin
    if (reset || enter_play) begin
      speed_q       <= '0;
      score_hi_prev <= '0;
    end else begin
      score_hi_prev <= score_q[SCORE_W-1:4];
      if (score_up) speed_q <= speed_nxt;
    end
  end

  assign bus.spawn      = spawn_q;
  assign bus.lane_busy  = busy_q;
  assign bus.speedshift = speed_q;
  assign bus.score      = score_q;
  assign bus.miss_count = miss_q;
  assign bus.gamestate  = state_q;
endmodule
